// File: rtl/asyc_fifo_pkg.sv
// ---------------------------------------------------------------------------
// asyc_fifo_pkg
// Shared definitions for the async FIFO pointer logic.
//   DEFAULT_ADDR_WIDTH : default RAM address width (DEPTH = 2**ADDR_WIDTH)
//   bin2gray / gray2bin: Gray conversions on right-justified values of any
//                        width up to GRAY_MAX_W bits. Callers zero-extend the
//                        input and truncate the result to their pointer width.
//                        Leading zero bits map to zero bits in both
//                        directions, so the conversions work at any width.
// ---------------------------------------------------------------------------
package asyc_fifo_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 6;
    localparam int GRAY_MAX_W         = 32;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] i_bin);
        return i_bin ^ (i_bin >> 1);
    endfunction

    // Prefix XOR from the MSB down, computed in log2(width) shift steps.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] i_gray);
        logic [GRAY_MAX_W-1:0] v_bin;
        v_bin = i_gray;
        for (int s = 1; s < GRAY_MAX_W; s = s * 2) begin
            v_bin = v_bin ^ (v_bin >> s);
        end
        return v_bin;
    endfunction

endpackage

// File: rtl/asyc_fifo_sync.sv
// ---------------------------------------------------------------------------
// asyc_fifo_sync
// N-stage flop synchronizer for a Gray-coded pointer crossing clock domains.
// Nothing combinational sits in front of the first flop.
//   i_clk   : destination-domain clock
//   i_rst_n : asynchronous active-low reset; clears every stage
//   i_d     : WIDTH-bit value from the source domain
//   o_q     : value after STAGES flops
// ---------------------------------------------------------------------------
module asyc_fifo_sync #(
    parameter int WIDTH  = 7,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_sync [STAGES];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/asyc_fifo_wptr_full.sv
// ---------------------------------------------------------------------------
// asyc_fifo_wptr_full
// Write-domain pointer and full-flag controller of the async FIFO.
// Holds the binary and Gray write pointers. Synchronizes the read domain's
// Gray pointer into write_clk and registers full, almost-full, fill level and
// a sticky overflow flag.
//   write_clk         : write-domain clock
//   write_rst_n       : asynchronous active-low reset
//   write_ena         : producer write request (dropped while write_full)
//   read_ptr_gray     : Gray read pointer from the read domain (async)
//   write_addr        : RAM write address = low bits of binary write pointer
//   write_ptr_gray    : registered Gray write pointer for the read domain
//   write_full        : registered full flag
//   write_almost_full : registered, level >= ALMOST_FULL_THRESH
//   write_level       : registered entry count 0..DEPTH seen from write side
//   write_overflow    : sticky, set by a write attempt while full
// Legal parameters: ADDR_WIDTH >= 2, SYNC_STAGES 2..4,
// ALMOST_FULL_THRESH 1..2**ADDR_WIDTH.
// ---------------------------------------------------------------------------
module asyc_fifo_wptr_full
    import asyc_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH         = DEFAULT_ADDR_WIDTH,
    parameter int SYNC_STAGES        = 2,
    parameter int ALMOST_FULL_THRESH = 60
) (
    input  logic                  write_clk,
    input  logic                  write_rst_n,
    input  logic                  write_ena,
    input  logic [ADDR_WIDTH:0]   read_ptr_gray,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [ADDR_WIDTH:0]   write_ptr_gray,
    output logic                  write_full,
    output logic                  write_almost_full,
    output logic [ADDR_WIDTH:0]   write_level,
    output logic                  write_overflow
);

    localparam int              PTR_W     = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0] AF_THRESH = PTR_W'(ALMOST_FULL_THRESH);

    logic [PTR_W-1:0] r_wbin;
    logic [PTR_W-1:0] r_wgray;
    logic [PTR_W-1:0] r_level;
    logic             r_full;
    logic             r_almost_full;
    logic             r_overflow;

    logic [PTR_W-1:0] w_rq_sync;
    logic [PTR_W-1:0] w_rbin;
    logic [PTR_W-1:0] w_wbin_next;
    logic [PTR_W-1:0] w_wgray_next;
    logic [PTR_W-1:0] w_level_next;
    logic [PTR_W-1:0] w_full_gray;
    logic             w_push;

    asyc_fifo_sync #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .i_clk   (write_clk),
        .i_rst_n (write_rst_n),
        .i_d     (read_ptr_gray),
        .o_q     (w_rq_sync)
    );

    always_comb begin
        w_push       = write_ena & ~r_full;
        w_wbin_next  = r_wbin + {{(PTR_W-1){1'b0}}, w_push};
        w_wgray_next = PTR_W'(bin2gray(GRAY_MAX_W'(w_wbin_next)));
        w_rbin       = PTR_W'(gray2bin(GRAY_MAX_W'(w_rq_sync)));
        // Modulo-2**PTR_W difference is the true occupancy, wrap included.
        w_level_next = w_wbin_next - w_rbin;
        // The write pointer is exactly one lap (DEPTH) ahead of the read
        // pointer when its top two Gray bits are inverted and the rest match.
        w_full_gray  = {~w_rq_sync[PTR_W-1:PTR_W-2], w_rq_sync[PTR_W-3:0]};
    end

    // Flags are computed from the next pointer, so full asserts on the same
    // edge that accepts the last free slot.
    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            r_wbin        <= '0;
            r_wgray       <= '0;
            r_level       <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_wbin        <= w_wbin_next;
            r_wgray       <= w_wgray_next;
            r_level       <= w_level_next;
            r_full        <= (w_wgray_next == w_full_gray);
            r_almost_full <= (w_level_next >= AF_THRESH);
            r_overflow    <= r_overflow | (write_ena & r_full);
        end
    end

    assign write_addr        = r_wbin[ADDR_WIDTH-1:0];
    assign write_ptr_gray    = r_wgray;
    assign write_full        = r_full;
    assign write_almost_full = r_almost_full;
    assign write_level       = r_level;
    assign write_overflow    = r_overflow;

endmodule

// File: tb/tb_asyc_fifo_wptr_full.sv
// ---------------------------------------------------------------------------
// tb_asyc_fifo_wptr_full
// Scoreboard bench: the stimulus side counts writes and reads as plain
// integers, derives the expected outputs for each clock edge and queues them;
// a monitor on the falling edge pops and compares against the DUT.
// ---------------------------------------------------------------------------
module tb_asyc_fifo_wptr_full;

    localparam int AW     = 6;
    localparam int DEPTH  = 64;
    localparam int SYNC   = 2;
    localparam int THRESH = 60;

    logic          write_clk;
    logic          write_rst_n;
    logic          write_ena;
    logic [AW:0]   read_ptr_gray;
    logic [AW-1:0] write_addr;
    logic [AW:0]   write_ptr_gray;
    logic          write_full;
    logic          write_almost_full;
    logic [AW:0]   write_level;
    logic          write_overflow;

    asyc_fifo_wptr_full #(
        .ADDR_WIDTH         (AW),
        .SYNC_STAGES        (SYNC),
        .ALMOST_FULL_THRESH (THRESH)
    ) dut (
        .write_clk         (write_clk),
        .write_rst_n       (write_rst_n),
        .write_ena         (write_ena),
        .read_ptr_gray     (read_ptr_gray),
        .write_addr        (write_addr),
        .write_ptr_gray    (write_ptr_gray),
        .write_full        (write_full),
        .write_almost_full (write_almost_full),
        .write_level       (write_level),
        .write_overflow    (write_overflow)
    );

    initial write_clk = 1'b0;
    always #5 write_clk = ~write_clk;

    typedef struct {
        int addr;
        int gray;
        int full;
        int af;
        int level;
        int ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference state: total accepted writes, total reads issued by the
    // read domain, and the read totals still travelling through the
    // synchronizer (hist[0] newest).
    int   m_wr;
    int   m_rd;
    int   hist[SYNC];
    bit   m_full;
    bit   m_ovf;

    function automatic int g7(input int v);
        int b;
        b = v % 128;
        return b ^ (b >> 1);
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        m_wr   = 0;
        m_rd   = 0;
        m_full = 1'b0;
        m_ovf  = 1'b0;
        for (int i = 0; i < SYNC; i++) hist[i] = 0;
    endtask

    // Drive one write_clk cycle and queue the outputs expected after its edge.
    task automatic step(input bit ena);
        exp_t e;
        int   rd_seen;
        int   lvl;
        write_ena     = ena;
        read_ptr_gray = 7'(g7(m_rd));
        rd_seen = hist[SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = m_rd;
        if (ena && m_full) m_ovf = 1'b1;
        if (ena && !m_full) m_wr++;
        lvl     = m_wr - rd_seen;
        m_full  = (lvl == DEPTH);
        e.addr  = m_wr % DEPTH;
        e.gray  = g7(m_wr);
        e.full  = int'(m_full);
        e.af    = (lvl >= THRESH) ? 1 : 0;
        e.level = lvl;
        e.ovf   = int'(m_ovf);
        exp_q.push_back(e);
        @(posedge write_clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge write_clk);
        #1;
        write_rst_n   = 1'b0;
        read_ptr_gray = '0;
        write_ena     = 1'b0;
        #1;
        chk("rst_addr",  write_addr,        0);
        chk("rst_gray",  write_ptr_gray,    0);
        chk("rst_full",  write_full,        0);
        chk("rst_af",    write_almost_full, 0);
        chk("rst_level", write_level,       0);
        chk("rst_ovf",   write_overflow,    0);
        model_reset();
        repeat (2) @(posedge write_clk);
        @(negedge write_clk);
        #1;
        write_rst_n = 1'b1;
    endtask

    // Monitor: every edge produces a full output set; compare it at the
    // following falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge write_clk);
            if (write_rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_addr",  write_addr,        e.addr);
                chk("sb_gray",  write_ptr_gray,    e.gray);
                chk("sb_full",  write_full,        e.full);
                chk("sb_af",    write_almost_full, e.af);
                chk("sb_level", write_level,       e.level);
                chk("sb_ovf",   write_overflow,    e.ovf);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int prev_gray;
        int rate[5];
        int adv;
        rate[0] = 95; rate[1] = 30; rate[2] = 80; rate[3] = 50; rate[4] = 99;

        write_rst_n   = 1'b0;
        write_ena     = 1'b0;
        read_ptr_gray = '0;
        model_reset();
        repeat (2) @(posedge write_clk);
        @(negedge write_clk);
        #1;
        write_rst_n = 1'b1;

        // Partial burst, then reset in the middle of it.
        for (int i = 0; i < 5; i++) step(1'b1);
        do_reset();
        step(1'b0);
        chk("post_rst_addr", write_addr, 0);
        chk("post_rst_gray", write_ptr_gray, 0);

        // Fill with the read pointer held at 0.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1);
            if (i == THRESH - 2) chk("af_before_thresh", write_almost_full, 0);
            if (i == THRESH - 1) chk("af_at_thresh", write_almost_full, 1);
            if (i == DEPTH - 2)  chk("not_full_at_63", write_full, 0);
        end
        chk("fill_full",  write_full, 1);
        chk("fill_level", write_level, 64);
        chk("fill_gray",  write_ptr_gray, 7'b1100000);

        // Writes while full are dropped and flagged.
        for (int i = 0; i < 3; i++) step(1'b1);
        chk("ovf_addr",  write_addr, 0);
        chk("ovf_level", write_level, 64);
        step(1'b0);
        chk("ovf_sticky", write_overflow, 1);

        // Read pointer advances to 4: visible on the third edge.
        m_rd = 4;
        step(1'b0);
        chk("drain_full_c1", write_full, 1);
        step(1'b0);
        chk("drain_full_c2", write_full, 1);
        step(1'b0);
        chk("drain_full_c3", write_full, 0);
        chk("drain_level",   write_level, 60);

        // Pointer wrap with the read pointer trailing by 10.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1);
        for (int i = 0; i < 130; i++) begin
            prev_gray = int'(write_ptr_gray);
            m_rd = m_wr - 10;
            step(1'b1);
            chk("wrap_gray_1bit", $countones(7'(prev_gray) ^ write_ptr_gray), 1);
            chk("wrap_no_full", write_full, 0);
        end
        chk("wrap_addr", write_addr, 140 % DEPTH);

        // Write on the same edge the synchronized read pointer moves by one.
        do_reset();
        for (int i = 0; i < 63; i++) step(1'b1);
        for (int i = 0; i < 3; i++) step(1'b0);
        chk("simul_level_pre", write_level, 63);
        m_rd = 1;
        step(1'b0);
        step(1'b0);
        step(1'b1);
        chk("simul_level", write_level, 63);
        chk("simul_full",  write_full, 0);

        // Randomized traffic with varying write pressure.
        for (int blk = 0; blk < 5; blk++) begin
            for (int i = 0; i < 300; i++) begin
                if (m_rd < m_wr && $urandom_range(0, 99) < 60) begin
                    adv = (m_wr - m_rd > 1) ? int'($urandom_range(1, 2)) : 1;
                    m_rd += adv;
                end
                step($urandom_range(0, 99) < rate[blk]);
            end
        end
        step(1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge write_clk);
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL sb_drain actual=%0d expected=0 pending entries", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
